// File: rtl/rob_commit_ctrl_if.sv
// ============================================================================
//  Module      : rob_commit_ctrl_if
//  Description : Issue / writeback / commit / flush bundle for rob_commit_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rob_commit_ctrl_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 rdy;
    logic                 alloc_req;
    logic [4:0]           alloc_rd;
    logic                 alloc_ok;
    logic [ROB_WIDTH-1:0] alloc_tag;
    logic                 full;
    logic                 wb_valid;
    logic [ROB_WIDTH-1:0] wb_tag;
    logic [31:0]          wb_val;
    logic                 wb_mispredict;
    logic [31:0]          wb_target;
    logic                 commit_sig;
    logic [4:0]           commit_reg;
    logic [31:0]          commit_val;
    logic [ROB_WIDTH:0]   commit_rob_tag;
    logic                 clear;
    logic [31:0]          redirect_pc;
    logic [ROB_WIDTH-1:0] q_tag;
    logic                 q_ready;
    logic [31:0]          q_val;

    modport master (
        output rdy, alloc_req, alloc_rd, wb_valid, wb_tag, wb_val, wb_mispredict,
               wb_target, q_tag,
        input  alloc_ok, alloc_tag, full, commit_sig, commit_reg, commit_val,
               commit_rob_tag, clear, redirect_pc, q_ready, q_val
    );

    modport slave (
        input  rdy, alloc_req, alloc_rd, wb_valid, wb_tag, wb_val, wb_mispredict,
               wb_target, q_tag,
        output alloc_ok, alloc_tag, full, commit_sig, commit_reg, commit_val,
               commit_rob_tag, clear, redirect_pc, q_ready, q_val
    );
endinterface

`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
// ============================================================================
//  Module      : rob_commit_ctrl
//  Description : In-order reorder-buffer commit sequencer with mispredict flush.
//                Optional operand query port enabled by ROB_QUERY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_commit_ctrl #(
    parameter int ROB_WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    rob_commit_ctrl_if.slave bus
);
    localparam int                 c_DEPTH      = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] c_FULL_COUNT = (ROB_WIDTH + 1)'(c_DEPTH);

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;
    logic [c_DEPTH-1:0]   r_busy;
    logic [c_DEPTH-1:0]   r_ready;
    logic [4:0]           r_rd      [c_DEPTH];
    logic [31:0]          r_val     [c_DEPTH];
    logic [c_DEPTH-1:0]   r_mispred;
    logic [31:0]          r_target  [c_DEPTH];

    logic                 r_commit_sig;
    logic [4:0]           r_commit_reg;
    logic [31:0]          r_commit_val;
    logic [ROB_WIDTH:0]   r_commit_rob_tag;
    logic                 r_clear;
    logic [31:0]          r_redirect_pc;

    logic w_full;
    logic w_alloc;
    logic w_wb;
    logic w_commit;
    logic w_flush;

    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_alloc  = bus.alloc_req & ~w_full & bus.rdy & ~r_clear;
    assign w_wb     = bus.wb_valid & bus.rdy & ~r_clear & r_busy[bus.wb_tag];
    assign w_commit = bus.rdy & ~r_clear & r_busy[r_head] & r_ready[r_head];
    assign w_flush  = w_commit & r_mispred[r_head];

    assign bus.alloc_ok       = w_alloc;
    assign bus.alloc_tag      = r_tail;
    assign bus.full           = w_full;
    assign bus.commit_sig     = r_commit_sig;
    assign bus.commit_reg     = r_commit_reg;
    assign bus.commit_val     = r_commit_val;
    assign bus.commit_rob_tag = r_commit_rob_tag;
    assign bus.clear          = r_clear;
    assign bus.redirect_pc    = r_redirect_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_busy           <= '0;
            r_ready          <= '0;
            r_commit_sig     <= 1'b0;
            r_commit_reg     <= '0;
            r_commit_val     <= '0;
            r_commit_rob_tag <= '0;
            r_clear          <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_commit_sig <= w_commit;
            r_clear      <= w_flush;
            if (w_commit) begin
                r_commit_reg     <= r_rd[r_head];
                r_commit_val     <= r_val[r_head];
                r_commit_rob_tag <= {1'b0, r_head};
            end
            // A flush overrides any same-cycle allocation or writeback.
            if (w_flush) begin
                r_redirect_pc <= r_target[r_head];
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_busy        <= '0;
                r_ready       <= '0;
            end else begin
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + 1'b1;
                end
                if (w_wb) begin
                    r_ready[bus.wb_tag] <= 1'b1;
                end
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                end
                r_count <= r_count + {{ROB_WIDTH{1'b0}}, w_alloc}
                                   - {{ROB_WIDTH{1'b0}}, w_commit};
            end
        end
    end

    // Payload storage needs no reset: it is only read behind busy/ready.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd[r_tail] <= bus.alloc_rd;
        end
        if (w_wb) begin
            r_val[bus.wb_tag]     <= bus.wb_val;
            r_mispred[bus.wb_tag] <= bus.wb_mispredict;
            r_target[bus.wb_tag]  <= bus.wb_target;
        end
    end

`ifdef ROB_QUERY_EN
    logic w_q_fwd;
    assign w_q_fwd     = bus.wb_valid & (bus.wb_tag == bus.q_tag);
    assign bus.q_ready = w_q_fwd | (r_busy[bus.q_tag] & r_ready[bus.q_tag]);
    assign bus.q_val   = w_q_fwd ? bus.wb_val : r_val[bus.q_tag];
`else
    logic w_unused_q;
    assign w_unused_q  = ^bus.q_tag;
    assign bus.q_ready = 1'b0;
    assign bus.q_val   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
// ============================================================================
//  Module      : tb_rob_commit_ctrl
//  Description : Scoreboard bench for rob_commit_ctrl (commit order, full/wrap,
//                flush, latency, rdy stall, query port).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_commit_ctrl;
    logic clk;
    logic rst;

    rob_commit_ctrl_if #(.ROB_WIDTH(4)) bus ();

    rob_commit_ctrl #(.ROB_WIDTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [4:0]  tag;
        logic        clr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] val, input logic [4:0] tag,
                            input logic clr, input logic [31:0] pc);
        exp_t e;
        e.rd = rd; e.val = val; e.tag = tag; e.clr = clr; e.pc = pc;
        sb.push_back(e);
    endtask

    // Commit monitor: every retirement must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.commit_sig || bus.clear)) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_commit", {63'd0, bus.commit_sig}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("commit_sig", {63'd0, bus.commit_sig}, 64'd1);
                chk_eq("commit_reg", {59'd0, bus.commit_reg}, {59'd0, e.rd});
                chk_eq("commit_val", {32'd0, bus.commit_val}, {32'd0, e.val});
                chk_eq("commit_tag", {59'd0, bus.commit_rob_tag}, {59'd0, e.tag});
                chk_eq("commit_clear", {63'd0, bus.clear}, {63'd0, e.clr});
                if (e.clr) chk_eq("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, e.pc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [3:0] exp_tag);
        bus.alloc_req = 1'b1;
        bus.alloc_rd  = rd;
        #2;
        chk_eq("alloc_ok", {63'd0, bus.alloc_ok}, 64'd1);
        chk_eq("alloc_tag", {60'd0, bus.alloc_tag}, {60'd0, exp_tag});
        step();
        bus.alloc_req = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic [31:0] val,
                         input logic mis, input logic [31:0] tgt);
        bus.wb_valid      = 1'b1;
        bus.wb_tag        = tag;
        bus.wb_val        = val;
        bus.wb_mispredict = mis;
        bus.wb_target     = tgt;
        step();
        bus.wb_valid      = 1'b0;
        bus.wb_mispredict = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk_eq("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1; bus.alloc_req = 1'b0; bus.alloc_rd = '0;
        bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_val = '0;
        bus.wb_mispredict = 1'b0; bus.wb_target = '0; bus.q_tag = '0;
        do_reset();
        chk_eq("rst_commit_sig", {63'd0, bus.commit_sig}, 64'd0);
        chk_eq("rst_commit_val", {32'd0, bus.commit_val}, 64'd0);
        chk_eq("rst_redirect", {32'd0, bus.redirect_pc}, 64'd0);
        chk_eq("rst_full", {63'd0, bus.full}, 64'd0);

        // Reset mid-run with 5 busy entries.
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 4'(i));
        chk_eq("pre_rst_tag", {60'd0, bus.alloc_tag}, 64'd5);
        #2 rst = 1'b1;
        #2 chk_eq("async_rst_tag", {60'd0, bus.alloc_tag}, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk_eq("mid_rst_tag", {60'd0, bus.alloc_tag}, 64'd0);
        chk_eq("mid_rst_full", {63'd0, bus.full}, 64'd0);
        chk_eq("mid_rst_commit", {63'd0, bus.commit_sig}, 64'd0);
        chk_eq("mid_rst_clear", {63'd0, bus.clear}, 64'd0);

        // Out-of-order writeback, in-order commit.
        do_alloc(5'd3, 4'd0); do_alloc(5'd5, 4'd1); do_alloc(5'd7, 4'd2);
        push_exp(5'd3, 32'hAA, 5'd0, 1'b0, 32'd0);
        push_exp(5'd5, 32'h11, 5'd1, 1'b0, 32'd0);
        push_exp(5'd7, 32'h22, 5'd2, 1'b0, 32'd0);
        do_wb(4'd1, 32'h11, 1'b0, 32'd0);
        do_wb(4'd0, 32'hAA, 1'b0, 32'd0);
        do_wb(4'd2, 32'h22, 1'b0, 32'd0);
        wait_drain(20);
        step();

        // Writeback-to-commit latency.
        do_alloc(5'd9, 4'd3);
        push_exp(5'd9, 32'h99, 5'd3, 1'b0, 32'd0);
        do_wb(4'd3, 32'h99, 1'b0, 32'd0);
        chk_eq("lat_n1", {63'd0, bus.commit_sig}, 64'd0);
        step();
        chk_eq("lat_n2", {63'd0, bus.commit_sig}, 64'd1);
        step();

        // rdy low for three cycles delays the commit by exactly three.
        do_alloc(5'd10, 4'd4);
        push_exp(5'd10, 32'hBEEF, 5'd4, 1'b0, 32'd0);
        do_wb(4'd4, 32'hBEEF, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.rdy = 1'b0;
            step();
            chk_eq("stall_no_commit", {63'd0, bus.commit_sig}, 64'd0);
        end
        bus.rdy = 1'b1;
        step();
        chk_eq("stall_commit", {63'd0, bus.commit_sig}, 64'd1);
        step();
        chk_eq("stall_no_dup", {63'd0, bus.commit_sig}, 64'd0);
        wait_drain(5);

        // Fill to full, refuse the 17th, free tag 0, wrap.
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 4'(i));
        chk_eq("full_set", {63'd0, bus.full}, 64'd1);
        bus.alloc_req = 1'b1;
        #2 chk_eq("full_refuse", {63'd0, bus.alloc_ok}, 64'd0);
        push_exp(5'd1, 32'h33, 5'd0, 1'b0, 32'd0);
        do_wb(4'd0, 32'h33, 1'b0, 32'd0);
        #2 chk_eq("full_refuse_commit", {63'd0, bus.alloc_ok}, 64'd0);
        step();
        bus.alloc_req = 1'b0;
        chk_eq("full_freed", {63'd0, bus.full}, 64'd0);
        do_alloc(5'd17, 4'd0);
        chk_eq("full_again", {63'd0, bus.full}, 64'd1);
        wait_drain(5);

        // Mispredict flush at tag 1 with tags 2-4 in flight.
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 4'(i));
        push_exp(5'd1, 32'h10, 5'd0, 1'b0, 32'd0);
        push_exp(5'd2, 32'h44, 5'd1, 1'b1, 32'h100);
        do_wb(4'd0, 32'h10, 1'b0, 32'd0);
        do_wb(4'd2, 32'h20, 1'b0, 32'd0);
        do_wb(4'd3, 32'h30, 1'b0, 32'd0);
        do_wb(4'd1, 32'h44, 1'b1, 32'h100);
        step();
        chk_eq("flush_clear", {63'd0, bus.clear}, 64'd1);
        bus.alloc_req = 1'b1;
        #2 chk_eq("flush_no_alloc", {63'd0, bus.alloc_ok}, 64'd0);
        step();
        bus.alloc_req = 1'b0;
        chk_eq("flush_clear_drop", {63'd0, bus.clear}, 64'd0);
        chk_eq("flush_tail", {60'd0, bus.alloc_tag}, 64'd0);
        repeat (4) step();
        chk_eq("flush_drained", 64'(sb.size()), 64'd0);

        // Query port with same-cycle writeback forwarding.
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 4'(i));
        bus.q_tag = 4'd4;
        #2 chk_eq("q_before", {63'd0, bus.q_ready}, 64'd0);
        bus.wb_valid = 1'b1; bus.wb_tag = 4'd4; bus.wb_val = 32'h5A;
        #2;
`ifdef ROB_QUERY_EN
        chk_eq("q_fwd_ready", {63'd0, bus.q_ready}, 64'd1);
        chk_eq("q_fwd_val", {32'd0, bus.q_val}, 64'h5A);
`else
        chk_eq("q_off_ready", {63'd0, bus.q_ready}, 64'd0);
        chk_eq("q_off_val", {32'd0, bus.q_val}, 64'd0);
`endif
        step();
        bus.wb_valid = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule

`default_nettype wire
